// File: rtl/param_ram_pkg.sv
// Shared types and helpers for the param_ram storage primitive.
// Holds the init FSM state type, read-during-write mode codes and the byte-merge helper.
package param_ram_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  // Widest word the merge helper handles; callers size-cast in and out.
  localparam int MERGE_MAX_W  = 1024;
  localparam int MERGE_MAX_BE = MERGE_MAX_W / 8;

  function automatic logic [MERGE_MAX_W-1:0] byte_merge(
    input logic [MERGE_MAX_W-1:0]  old_word,
    input logic [MERGE_MAX_W-1:0]  new_word,
    input logic [MERGE_MAX_BE-1:0] be
  );
    logic [MERGE_MAX_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < MERGE_MAX_BE; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/param_ram_init_ctrl.sv
// Clear-sweep controller: walks every address once after reset or on clear_req,
// holding init_busy high for exactly DEPTH cycles.
module param_ram_init_ctrl
  import param_ram_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_req,
  output logic              init_busy,
  output logic              sweep_we,
  output logic [ADDR_W-1:0] sweep_addr
);

  state_t            state;
  logic [ADDR_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      case (state)
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == {ADDR_W{1'b1}}) state <= READY;
        end
        READY: begin
          // A request arriving mid-sweep never reaches here, so it cannot restart the count.
          if (clear_req) begin
            state <= CLEAR;
            cnt   <= '0;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  assign init_busy  = (state == CLEAR);
  assign sweep_we   = init_busy;
  assign sweep_addr = cnt;

endmodule

// File: rtl/param_ram.sv
// Simple dual-port synchronous RAM with byte enables, selectable read-during-write
// and a hardware clear sweep. Define PARAM_RAM_OUT_REG_EN for a second output stage (latency 2).
module param_ram
  import param_ram_pkg::*;
#(
  parameter int                ADDR_W   = 4,
  parameter int                DATA_W   = 8,
  parameter int                RDW_MODE = RDW_OLD,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  input  logic                clear_req,
  output logic                init_busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = DATA_W / 8;

  if ((DATA_W % 8) != 0 || DATA_W > MERGE_MAX_W) begin : g_bad_width
    $error("param_ram: DATA_W must be a multiple of 8 and at most MERGE_MAX_W");
  end

  logic              sweep_we;
  logic [ADDR_W-1:0] sweep_addr;

  param_ram_init_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_init_ctrl (
    .clk        (clk),
    .rst        (rst),
    .clear_req  (clear_req),
    .init_busy  (init_busy),
    .sweep_we   (sweep_we),
    .sweep_addr (sweep_addr)
  );

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array has no reset; the clear sweep is what initialises it.
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem[sweep_addr] <= INIT_VAL;
    end else if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  logic [DATA_W-1:0] rd_old;
  logic [DATA_W-1:0] rd_word;
  logic              rdw_hit;

  assign rd_old  = mem[rd_addr];
  assign rdw_hit = wr_en && (wr_addr == rd_addr);

  // NOTE: the default assignment first keeps this combinational block latch-free.
  always_comb begin
    rd_word = rd_old;
    if (RDW_MODE == RDW_NEW && rdw_hit) begin
      rd_word = DATA_W'(byte_merge(MERGE_MAX_W'(rd_old), MERGE_MAX_W'(wr_data),
                                   MERGE_MAX_BE'(wr_be)));
    end
  end

  logic [DATA_W-1:0] rd_data_s1;
  logic              rd_valid_s1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_s1  <= '0;
      rd_valid_s1 <= 1'b0;
    end else if (init_busy) begin
      rd_valid_s1 <= 1'b0;
    end else begin
      rd_valid_s1 <= rd_en;
      if (rd_en) rd_data_s1 <= rd_word;
    end
  end

`ifdef PARAM_RAM_OUT_REG_EN
  logic [DATA_W-1:0] rd_data_s2;
  logic              rd_valid_s2;

  // Second stage only forwards completed reads, so rd_data still holds between them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_s2  <= '0;
      rd_valid_s2 <= 1'b0;
    end else begin
      rd_valid_s2 <= rd_valid_s1;
      if (rd_valid_s1) rd_data_s2 <= rd_data_s1;
    end
  end

  assign rd_data  = rd_data_s2;
  assign rd_valid = rd_valid_s2;
`else
  assign rd_data  = rd_data_s1;
  assign rd_valid = rd_valid_s1;
`endif

endmodule

// File: doc/param_ram.md
Name: param_ram

Overview:
- Parametrised successor to the single-port 16x8 scratch RAM.
- Simple dual-port synchronous RAM: one write port and one read port, generic width and depth, per-byte write enables, selectable read-during-write mode.
- Hardware clear sweep after reset and on request; read-valid strobe.
- Serves as the common storage primitive for upcoming FIFOs and register files.

Parameters:
- DATA_W, 8, data width in bits; must be a multiple of 8.
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W.
- RDW_MODE, 0, same-address read during write: 0 returns old data, 1 returns new (byte-merged) data.
- INIT_VAL, 0, DATA_W-bit value written to every word by the clear sweep.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_be  in  DATA_W/8  byte enables; bit i covers wr_data[8i+7:8i].
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  DATA_W  registered read data.
- rd_valid  out  1  high when rd_data carries the result of a read request.
- clear_req  in  1  single-cycle request to re-run the clear sweep.
- init_busy  out  1  high while the clear sweep runs; ports ignored.

Behaviour:
- Reset (async assert): state=CLEAR, sweep counter=0, rd_data=0, rd_valid=0, init_busy=1. Memory array is not reset; the sweep initialises it.
- States:
  - CLEAR: write INIT_VAL to mem[cnt] each cycle, cnt++. When cnt==DEPTH-1 is written, go to READY next cycle. Sweep takes exactly DEPTH cycles after reset release.
  - READY: normal operation, init_busy=0.
  - clear_req in READY -> CLEAR with cnt=0. clear_req during CLEAR is ignored (no restart).
- During CLEAR:
  - wr_en and rd_en are ignored; no memory update.
  - rd_valid=0; rd_data holds its last value.
- Write (READY, wr_en=1): for each i with wr_be[i]=1, set mem[wr_addr] byte i to wr_data byte i; other bytes are unchanged. wr_be=0 is a legal no-op.
- Read (READY, rd_en=1):
  - Latency 1: rd_data = mem[rd_addr] at the next edge, rd_valid=1 for that cycle.
  - rd_en=0: rd_valid=0 next cycle; rd_data holds.
- Same-cycle read and write to the same address:
  - RDW_MODE=0: rd_data = pre-write contents.
  - RDW_MODE=1: rd_data = old bytes where wr_be=0, new bytes where wr_be=1.
- Different addresses: fully independent, one read and one write per cycle.
- clear_req coinciding with wr_en/rd_en in READY: that cycle's write and read still complete; the sweep starts next cycle.
- Reset mid-sweep: restarts at cnt=0. Reset mid-read: rd_valid=0 immediately.
- Addresses are always in range (DEPTH = 2**ADDR_W); no wrap logic is needed.

Optional Feature:
- Macro: PARAM_RAM_OUT_REG_EN.
- Defined: extra output pipeline register on rd_data and rd_valid; read latency is 2. Both registers reset to 0. RDW behaviour is unchanged (resolved at stage 1).
- Undefined: latency 1 as above.

Decomposition:
- Package param_ram_pkg:
  - state enum {CLEAR, READY};
  - RDW_OLD=0 and RDW_NEW=1 constants;
  - byte-merge function (old, new, be) -> merged word.
- Sub-module param_ram_init_ctrl: CLEAR/READY FSM plus sweep counter; outputs init_busy, sweep write enable and sweep address.
- Top level holds the array, port muxing, RDW logic and output registers.

Test Plan (DATA_W=16, ADDR_W=4, RDW_MODE=0, macro off unless stated):
- Release reset; read all 16 addresses after init_busy falls -> init_busy high exactly 16 cycles; every read returns 16'h0000 with rd_valid one cycle after rd_en.
- Write 0xAAAA@0, 0xBBBB@1, 0xCCCC@2 with be=2'b11, then read 0,1,2 back-to-back -> rd_data 0xAAAA, 0xBBBB, 0xCCCC on consecutive cycles, rd_valid high for 3 cycles.
- Write 0x1234@5 be=11, then 0xFF00@5 be=10, read 5 -> 0xFF34.
- Same cycle: write 0x5555@3 while reading 3 (old 0x0000) -> RDW_MODE=0 returns 0x0000; rerun with RDW_MODE=1 -> 0x5555; be=01 with RDW_MODE=1 -> 0x0055.
- Assert clear_req after data is written; issue writes/reads during the sweep -> init_busy high 16 cycles, rd_valid stays 0, all words read back 0x0000; reset pulsed mid-sweep restarts the 16-cycle count.
- PARAM_RAM_OUT_REG_EN defined: write 0xBEEF@7, read 7 -> rd_data 0xBEEF and rd_valid exactly 2 cycles after rd_en.
